cmd_dispatch: RTL
=================

CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd4096, meaning the maximum number of BUSY cycles before forced completion (used only with CMD_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst, input, 1; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port command_in, input, 40, the instruction word: [4:0] opcode, [6:5] unit select, [39:7] operand.
REQ-005 SHALL have port command_we, input, 1, command valid strobe from the program controller.
REQ-006 SHALL have port unit_done, input, 4, per-unit completion pulses.
REQ-007 SHALL have port err_clear, input, 1, clears sticky error flags.
REQ-008 SHALL have port unit_start, output, 4, one-hot start pulse to the execution units.
REQ-009 SHALL have port cmd_opcode, output, 5, registered opcode.
REQ-010 SHALL have port cmd_operand, output, 33, registered operand.
REQ-011 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-012 SHALL have port done_ins_computation, output, 1, single-cycle completion pulse to the program controller.
REQ-013 SHALL have ports err_overrun and err_timeout, output, 1 each, sticky error flags.
REQ-014 SHALL have port instr_count, output, 16, count of completed dispatched instructions.

Function
REQ-015 SHALL implement states IDLE, LAUNCH, BUSY, DONE.
REQ-016 In IDLE with command_we=1 and opcode not in {5'd0, 5'd31}, the block SHALL capture opcode, unit select and operand on that edge and enter LAUNCH.
REQ-017 Opcodes 5'd0 (NOP) and 5'd31 (END) SHALL be ignored: no capture, no start, no done pulse, and the state stays IDLE.
REQ-018 LAUNCH SHALL assert unit_start[sel] for exactly one cycle, then enter BUSY; the start pulse occurs 1 cycle after the command_we edge.
REQ-019 BUSY SHALL wait for unit_done[sel]=1; done bits from non-selected units SHALL be ignored.
REQ-020 When unit_done[sel] is sampled in BUSY, the block SHALL enter DONE; DONE SHALL assert done_ins_computation for one cycle, increment instr_count, and return to IDLE.
REQ-021 unit_done[sel] asserted during LAUNCH SHALL be honoured: BUSY is skipped and the next state is DONE.
REQ-022 command_we=1 in LAUNCH, BUSY or DONE SHALL be dropped and SHALL set err_overrun; captured fields remain unchanged.
REQ-023 instr_count SHALL wrap from 16'hFFFF to 0.
REQ-024 err_clear SHALL clear both error flags; a set event in the same cycle as err_clear SHALL win.
REQ-025 cmd_opcode and cmd_operand SHALL hold their values until the next accepted command.

Reset
REQ-026 On rst=1 (asynchronous), the state SHALL go to IDLE, and unit_start, cmd_opcode, cmd_operand, busy, done_ins_computation, err_overrun, err_timeout and instr_count SHALL all be 0.
REQ-027 Reset during BUSY SHALL abandon the instruction without a done pulse; a later unit_done SHALL be ignored.

Configuration
REQ-028 Macro CMD_TIMEOUT_EN: when defined, a 16-bit BUSY-cycle counter SHALL clear on entry to BUSY. On reaching TIMEOUT_CYCLES it SHALL set err_timeout and force DONE, with a normal done pulse and an instr_count increment.
REQ-029 Without CMD_TIMEOUT_EN, there SHALL be no counter, err_timeout SHALL be tied to 0, and BUSY waits indefinitely.

Structure
REQ-030 Package cmd_dispatch_pkg SHALL hold the state encoding, the command field bit positions, OP_NOP=5'd0, OP_END=5'd31 and NUM_UNITS=4.
REQ-031 Sub-module dispatch_watchdog (the timeout counter) SHALL be instantiated only under CMD_TIMEOUT_EN.

Verification
REQ-032 Scenario: command 40'h0000_0000_41 (opcode 1, sel 2) strobed in IDLE -> unit_start=4'b0100 one cycle later; unit_done[2] 5 cycles later -> done pulse the following cycle; instr_count=1.
REQ-033 Scenario: opcode 0 and then opcode 31 strobed -> no unit_start, no done pulse, busy stays 0.
REQ-034 Scenario: command_we during BUSY -> err_overrun=1 and cmd_operand unchanged; err_clear -> err_overrun=0.
REQ-035 Scenario: sel=1 in BUSY with unit_done=4'b0001 -> no completion; unit_done=4'b0010 -> done pulse.
REQ-036 Scenario: with CMD_TIMEOUT_EN and TIMEOUT_CYCLES=8, no unit_done -> err_timeout=1 and a done pulse after 8 BUSY cycles.
REQ-037 Scenario: rst asserted in BUSY -> immediate IDLE with all outputs 0; a subsequent unit_done gives no done pulse.

Source files
------------

// File: rtl/cmd_dispatch_pkg.sv
// Shared definitions for the command dispatcher: state encoding, command word
// field positions, reserved opcodes and the execution-unit count.
// Optional timeout support is enabled with the CMD_TIMEOUT_EN macro.
package cmd_dispatch_pkg;

  localparam int NUM_UNITS = 4;
  localparam int CMD_W     = 40;
  localparam int OPC_W     = 5;
  localparam int SEL_W     = 2;
  localparam int OPD_W     = 33;

  // Command word layout: [4:0] opcode, [6:5] unit select, [39:7] operand
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 4;
  localparam int SEL_LSB = 5;
  localparam int SEL_MSB = 6;
  localparam int OPD_LSB = 7;
  localparam int OPD_MSB = 39;

  // Opcodes that the controller may emit but that never reach a unit
  localparam logic [OPC_W-1:0] OP_NOP = 5'd0;
  localparam logic [OPC_W-1:0] OP_END = 5'd31;

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_BUSY   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // True when the opcode must be dispatched to an execution unit
  function automatic logic is_dispatchable(input logic [OPC_W-1:0] op);
    return (op != OP_NOP) && (op != OP_END);
  endfunction

  // One-hot decode of the unit select field
  function automatic logic [NUM_UNITS-1:0] unit_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_UNITS-1:0] oh;
    oh = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/cmd_dispatch_watchdog.sv
// BUSY-cycle watchdog: counts cycles spent waiting on a unit and flags expiry.
// Expiry is combinational in the cycle whose count reaches LIMIT.
// Only compiled when CMD_TIMEOUT_EN is defined, matching its sole instantiation.
`ifdef CMD_TIMEOUT_EN
module dispatch_watchdog #(
  parameter logic [15:0] LIMIT = 16'd4096
) (
  input  logic clk,
  input  logic rst,
  input  logic arm,       // high in the cycle before BUSY is entered
  input  logic counting,  // high while in BUSY
  output logic expired
);

  logic [15:0] cnt;

  // Restart on every launch so each instruction gets a full budget
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (arm) begin
      cnt <= '0;
    end else if (counting) begin
      cnt <= cnt + 16'd1;
    end
  end

  // cnt holds the number of BUSY cycles already completed; this cycle is one more
  assign expired = counting && (({1'b0, cnt} + 17'd1) >= {1'b0, LIMIT});

endmodule
`endif

// File: rtl/cmd_dispatch.sv
// Command dispatcher: accepts instruction words, starts one execution unit,
// waits for its completion and reports back with a single-cycle done pulse.
// Optional BUSY timeout is enabled with the CMD_TIMEOUT_EN macro.
module cmd_dispatch
  import cmd_dispatch_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CMD_W-1:0]     command_in,
  input  logic                 command_we,
  input  logic [NUM_UNITS-1:0] unit_done,
  input  logic                 err_clear,
  output logic [NUM_UNITS-1:0] unit_start,
  output logic [OPC_W-1:0]     cmd_opcode,
  output logic [OPD_W-1:0]     cmd_operand,
  output logic                 busy,
  output logic                 done_ins_computation,
  output logic                 err_overrun,
  output logic                 err_timeout,
  output logic [15:0]          instr_count
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [SEL_W-1:0] sel_q;
  logic [OPC_W-1:0] opc_in;
  logic             accept;
  logic             sel_done;
  logic             wd_expired;
  logic             timeout_set;
  logic             overrun_set;

  assign opc_in      = command_in[OPC_MSB:OPC_LSB];
  assign accept      = (state == ST_IDLE) && command_we && is_dispatchable(opc_in);
  assign sel_done    = unit_done[sel_q];
  assign overrun_set = command_we && (state != ST_IDLE);
  // A real completion in the same cycle as expiry is not an error
  assign timeout_set = (state == ST_BUSY) && wd_expired && !sel_done;

`ifdef CMD_TIMEOUT_EN
  dispatch_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .arm      (state == ST_LAUNCH),
    .counting (state == ST_BUSY),
    .expired  (wd_expired)
  );

  // Sticky timeout flag; a new timeout beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_timeout <= 1'b0;
    end else if (timeout_set) begin
      err_timeout <= 1'b1;
    end else if (err_clear) begin
      err_timeout <= 1'b0;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, timeout_set};
  assign wd_expired  = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Next-state selection; completion during LAUNCH skips BUSY entirely
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_LAUNCH;
      ST_LAUNCH: state_nxt = sel_done ? ST_DONE : ST_BUSY;
      ST_BUSY:   if (sel_done || wd_expired) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture command fields only on an accepted command; held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_opcode  <= '0;
      cmd_operand <= '0;
      sel_q       <= '0;
    end else if (accept) begin
      cmd_opcode  <= opc_in;
      cmd_operand <= command_in[OPD_MSB:OPD_LSB];
      sel_q       <= command_in[SEL_MSB:SEL_LSB];
    end
  end

  // Completed-instruction counter, wraps naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= '0;
    end else if (state == ST_DONE) begin
      instr_count <= instr_count + 16'd1;
    end
  end

  // Sticky overrun flag; a new overrun beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overrun <= 1'b0;
    end else if (overrun_set) begin
      err_overrun <= 1'b1;
    end else if (err_clear) begin
      err_overrun <= 1'b0;
    end
  end

  // Outputs decoded directly from the registered state
  assign unit_start           = (state == ST_LAUNCH) ? unit_onehot(sel_q) : '0;
  assign busy                 = (state != ST_IDLE);
  assign done_ins_computation = (state == ST_DONE);

endmodule
